block_map: RTL and testbench
============================

# block_map

Arena block-map store: holds the 33×27 tile map of destructible (soft) blocks, regenerates it pseudo-randomly on reset or on request, and serves as the responder for explosion clear-writes issued by the bomb logic (address = x + 33·y, write enable). It provides two registered tile-query ports, one for the VGA tile renderer and one for bomberman collision. It also maintains a live soft-block count used for level-clear detection.

## Interface
- DENSITY, 160: soft-block fill threshold, 0..256; a cell is filled when LFSR[7:0] < DENSITY.
- LFSR_SEED, 16'hACE1: nonzero LFSR value loaded at reset.
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- new_map  in  1  single-cycle pulse; regenerate the map
- w_addr  in  10  clear address, x + 33·y
- we  in  1  clear strobe; the addressed cell becomes empty
- vga_x, vga_y  in  6 each  renderer tile coordinates
- vga_block  out  2  tile type at (vga_x, vga_y): 0 empty, 1 soft, 2 pillar/wall
- col_x, col_y  in  6 each  collision tile coordinates
- col_block  out  2  tile type at (col_x, col_y), same encoding
- busy  out  1  high while the map is being generated
- blocks_left  out  10  soft blocks currently present
- all_clear  out  1  high when !busy and blocks_left == 0

## Operation
- Storage: 891 × 1-bit soft-block array. A pillar exists at every tile with x odd and y odd; pillars are computed combinationally and never stored.
- Wall: any query with x > 32 or y > 26 returns 2.
- FSM states:
  - FILL: fill_addr runs 0..890, one cell per clock. Tile x/y counters track fill_addr, with x wrapping 32→0 and incrementing y. Written bit = (LFSR[7:0] < DENSITY) & !pillar & !spawn, where spawn = {(0,0), (1,0), (0,1)}. blocks_left increments once per written 1. The LFSR steps every FILL cycle; taps 16,14,13,11, Fibonacci, shift left.
  - READY: accepts clears.
  - Transitions: FILL→READY after the write of address 890. READY→FILL on new_map; entering FILL clears blocks_left and fill_addr.
- The LFSR is not reseeded on new_map, so successive maps differ.
- new_map during FILL restarts from address 0 with blocks_left cleared.
- Clear-write behaviour in READY with we=1:
  - w_addr ≤ 890 and the cell holds 1: the cell becomes 0 and blocks_left decrements.
  - Cell already 0: no change. This covers pillar addresses and repeated explosions.
  - w_addr ≥ 891: ignored.
- we during FILL is ignored.
- If we and new_map arrive in the same cycle, new_map wins and the write is dropped.
- Query ports: address = x + 33·y, computed in 10 bits. Result priority: wall > pillar > stored bit. While busy, non-wall/non-pillar results are 0.
- blocks_left never underflows; decrement only occurs when the stored bit is 1.

## Timing
- Reset values:
  - State FILL, fill_addr 0, LFSR = LFSR_SEED, blocks_left 0.
  - busy 1, all_clear 0, vga_block 0, col_block 0.
- Generation starts on the first clock after reset_n deasserts.
- Generation takes 891 cycles. busy falls in the cycle after address 890 is written, and blocks_left is final at that same edge.
- Query latency: 1 cycle. Outputs are registered from the coordinates present at the prior edge.
- A query and a write to the same cell in the same cycle return the pre-write value; the next cycle returns the new value.
- blocks_left and all_clear update on the edge that performs the clear.
- busy rises on the edge after a new_map pulse.
- reset_n asserted mid-FILL or mid-READY immediately forces the reset values; the array contents become don't-care and are overwritten by the following FILL.

## Test plan
- DENSITY=256, release reset, wait for busy to fall: the fall occurs 891 cycles after the first edge. blocks_left = 680 (891 − 208 pillars − 3 spawn). Queries return (0,0)→0, (1,1)→2, (2,0)→1, (33,0)→2, (0,27)→2.
- DENSITY=0: after generation, blocks_left = 0 and all_clear = 1. No query returns 1.
- DENSITY=256 then clears, one per cycle:
  - w_addr 2 → blocks_left 679, and (2,0) reads 0 one cycle later.
  - Repeat w_addr 2 → stays 679.
  - w_addr 34 (pillar) → 679.
  - w_addr 900 → 679.
- Same-cycle query of (2,0) while clearing address 2 → returns 1; the next query returns 0.
- Mid-FILL new_map at cycle 400 → busy stays high, and completion occurs 891 cycles after the restart. we pulses during FILL have no effect on the final blocks_left.
- Two successive new_map generations with DENSITY=160 → the maps differ. Assert reset_n low mid-READY → busy=1 and blocks_left=0 immediately.

Source files
------------

// File: rtl/block_map_if.sv
// Bundle of the block-map store's control, clear-write, tile-query and status signals.
// The master side drives requests and coordinates; the slave side is block_map.
interface block_map_if;
   logic       new_map;
   logic [9:0] w_addr;
   logic       we;
   logic [5:0] vga_x;
   logic [5:0] vga_y;
   logic [5:0] col_x;
   logic [5:0] col_y;
   logic [1:0] vga_block;
   logic [1:0] col_block;
   logic       busy;
   logic [9:0] blocks_left;
   logic       all_clear;

   modport master (
      output new_map, w_addr, we, vga_x, vga_y, col_x, col_y,
      input  vga_block, col_block, busy, blocks_left, all_clear
   );

   modport slave (
      input  new_map, w_addr, we, vga_x, vga_y, col_x, col_y,
      output vga_block, col_block, busy, blocks_left, all_clear
   );
endinterface

// File: rtl/block_map.sv
// Arena soft-block map: LFSR-driven generation, explosion clear-writes, two registered
// tile-query ports and a live soft-block count for level-clear detection.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_FILL  | writing one generated cell per clock, fill_addr 0..890; busy
//   S_READY | map stable; clear-writes accepted; new_map restarts generation
module block_map #(
   parameter int          DENSITY   = 160,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic        clk,
   input logic        reset_n,
   block_map_if.slave bus
);

   localparam logic [9:0] LAST_ADDR = 10'd890;
   localparam logic [8:0] DENS9     = 9'(DENSITY);

   typedef enum logic {S_FILL, S_READY} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [9:0]  fill_addr_q;
   logic [5:0]  fill_x_q;
   logic [4:0]  fill_y_q;
   logic [15:0] lfsr_q;
   logic [9:0]  blocks_left_q;
   logic        soft_q [0:890];
   logic [1:0]  vga_block_q;
   logic [1:0]  col_block_q;

   logic        fill_restart;
   logic        fill_step;
   logic        clr_en;
   logic        busy;
   logic        lfsr_fb;
   logic [9:0]  dens_diff;
   logic        fill_hit;
   logic        fill_pillar;
   logic        fill_spawn;
   logic        fill_bit;
   logic        w_in_range;
   logic        w_cell;
   logic [9:0]  vga_addr;
   logic [9:0]  col_addr;
   logic        vga_soft;
   logic        col_soft;
   logic [1:0]  vga_code;
   logic [1:0]  col_code;

   assign busy    = (state_q == S_FILL);
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Sign of (lfsr - DENSITY) gives lfsr < DENSITY for the full 0..256 range.
   assign dens_diff   = {2'b00, lfsr_q[7:0]} - {1'b0, DENS9};
   assign fill_hit    = dens_diff[9];
   assign fill_pillar = fill_x_q[0] & fill_y_q[0];
   assign fill_spawn  = ((fill_y_q == 5'd0) && (fill_x_q <= 6'd1)) ||
                        ((fill_y_q == 5'd1) && (fill_x_q == 6'd0));
   assign fill_bit    = fill_hit & ~fill_pillar & ~fill_spawn;

   assign w_in_range = (bus.w_addr <= LAST_ADDR);
   assign w_cell     = w_in_range ? soft_q[bus.w_addr] : 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fill_restart = 1'b0;
      fill_step    = 1'b0;
      clr_en       = 1'b0;
      case (state_q)
         S_FILL: begin
            if (bus.new_map) begin
               fill_restart = 1'b1;
            end else begin
               fill_step = 1'b1;
               if (fill_addr_q == LAST_ADDR) begin
                  state_d = S_READY;
               end
            end
         end
         S_READY: begin
            if (bus.new_map) begin
               fill_restart = 1'b1;
               state_d      = S_FILL;
            end else if (bus.we && w_cell) begin
               clr_en = 1'b1;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_addr_q   <= '0;
         fill_x_q      <= '0;
         fill_y_q      <= '0;
         blocks_left_q <= '0;
      end else if (fill_restart) begin
         fill_addr_q   <= '0;
         fill_x_q      <= '0;
         fill_y_q      <= '0;
         blocks_left_q <= '0;
      end else if (fill_step) begin
         fill_addr_q   <= fill_addr_q + 10'd1;
         blocks_left_q <= blocks_left_q + {9'd0, fill_bit};
         if (fill_x_q == 6'd32) begin
            fill_x_q <= '0;
            fill_y_q <= fill_y_q + 5'd1;
         end else begin
            fill_x_q <= fill_x_q + 6'd1;
         end
      end else if (clr_en) begin
         blocks_left_q <= blocks_left_q - 10'd1;
      end
   end

   // The LFSR free-runs through every generation cycle and is never reseeded by new_map.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= LFSR_SEED;
      end else if (busy) begin
         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      end
   end

   always_ff @(posedge clk) begin
      if (fill_step) begin
         soft_q[fill_addr_q] <= fill_bit;
      end else if (clr_en) begin
         soft_q[bus.w_addr] <= 1'b0;
      end
   end

   assign vga_addr = {4'd0, bus.vga_x} + {4'd0, bus.vga_y} * 10'd33;
   assign col_addr = {4'd0, bus.col_x} + {4'd0, bus.col_y} * 10'd33;
   assign vga_soft = (vga_addr <= LAST_ADDR) ? soft_q[vga_addr] : 1'b0;
   assign col_soft = (col_addr <= LAST_ADDR) ? soft_q[col_addr] : 1'b0;

   function automatic logic [1:0] tile_code(input logic [5:0] x, input logic [5:0] y,
                                            input logic soft_bit, input logic gen);
      logic [1:0] code;
      if ((x > 6'd32) || (y > 6'd26)) begin
         code = 2'd2;
      end else if (x[0] & y[0]) begin
         code = 2'd2;
      end else if (gen) begin
         code = 2'd0;
      end else begin
         code = {1'b0, soft_bit};
      end
      return code;
   endfunction

   assign vga_code = tile_code(bus.vga_x, bus.vga_y, vga_soft, busy);
   assign col_code = tile_code(bus.col_x, bus.col_y, col_soft, busy);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vga_block_q <= '0;
         col_block_q <= '0;
      end else begin
         vga_block_q <= vga_code;
         col_block_q <= col_code;
      end
   end

   assign bus.vga_block   = vga_block_q;
   assign bus.col_block   = col_block_q;
   assign bus.busy        = busy;
   assign bus.blocks_left = blocks_left_q;
   assign bus.all_clear   = ~busy & (blocks_left_q == 10'd0);

endmodule

// File: tb/tb_block_map.sv
// Scoreboard bench for block_map: three instances (DENSITY 160, 256, 0) share stimulus;
// a map-level reference model predicts every registered output.
module tb_block_map;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       nm_r;
   logic       we_r;
   logic [9:0] wa_r;
   logic [5:0] vx_r, vy_r, cx_r, cy_r;

   logic [1:0] vga_o [3];
   logic [1:0] col_o [3];
   logic       busy_o [3];
   logic [9:0] bl_o [3];
   logic       ac_o [3];

   always #5 clk = ~clk;

   block_map_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].new_map = nm_r;
      assign bus[g].we      = we_r;
      assign bus[g].w_addr  = wa_r;
      assign bus[g].vga_x   = vx_r;
      assign bus[g].vga_y   = vy_r;
      assign bus[g].col_x   = cx_r;
      assign bus[g].col_y   = cy_r;
      assign vga_o[g]  = bus[g].vga_block;
      assign col_o[g]  = bus[g].col_block;
      assign busy_o[g] = bus[g].busy;
      assign bl_o[g]   = bus[g].blocks_left;
      assign ac_o[g]   = bus[g].all_clear;

      block_map #(
         .DENSITY   ((g == 0) ? 160 : ((g == 1) ? 256 : 0)),
         .LFSR_SEED (16'hACE1)
      ) u_dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus[g])
      );
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   int          dens [3] = '{160, 256, 0};
   bit          mmap [3][891];
   int          mcnt [3];
   bit          mbusy;
   int          fill_left;
   logic [15:0] fill_start_lfsr;
   logic [15:0] lfsr_after;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   task automatic gen_maps(input logic [15:0] l0);
      logic [15:0] l;
      int x, y;
      bit pil, spn, b;
      l = l0;
      for (int d = 0; d < 3; d++) mcnt[d] = 0;
      for (int i = 0; i < 891; i++) begin
         x   = i % 33;
         y   = i / 33;
         pil = (x % 2 == 1) && (y % 2 == 1);
         spn = (i == 0) || (i == 1) || (i == 33);
         for (int d = 0; d < 3; d++) begin
            b = (int'(l[7:0]) < dens[d]) && !pil && !spn;
            mmap[d][i] = b;
            mcnt[d] += int'(b);
         end
         l = lfsr_next(l);
      end
      fill_start_lfsr = l0;
      lfsr_after      = l;
   endtask

   function automatic int ref_tile(input int d, input int x, input int y, input bit gen);
      if (x > 32 || y > 26) return 2;
      if ((x % 2 == 1) && (y % 2 == 1)) return 2;
      if (gen) return 0;
      return mmap[d][x + 33 * y] ? 1 : 0;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int at_cyc;
      int d;
      int vga;
      int col;
      bit busy;
      bit chk_bl;
      int bl;
      bit ac;
   } exp_t;

   exp_t sb [$];

   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
         e = sb.pop_front();
         if (e.at_cyc < cyc) begin
            chk($sformatf("sb_late_d%0d", e.d), cyc, e.at_cyc);
         end else begin
            chk($sformatf("vga_d%0d_c%0d", e.d, cyc), int'(vga_o[e.d]), e.vga);
            chk($sformatf("col_d%0d_c%0d", e.d, cyc), int'(col_o[e.d]), e.col);
            chk($sformatf("busy_d%0d_c%0d", e.d, cyc), int'(busy_o[e.d]), int'(e.busy));
            chk($sformatf("allclr_d%0d_c%0d", e.d, cyc), int'(ac_o[e.d]), int'(e.ac));
            if (e.chk_bl)
               chk($sformatf("left_d%0d_c%0d", e.d, cyc), int'(bl_o[e.d]), e.bl);
         end
      end
   end

   // One clock of stimulus: drive, predict, push, then advance past the edge.
   task automatic cycle(input bit nm, input bit w, input int wa,
                        input int vx, input int vy, input int cx, input int cy);
      int  qv [3];
      int  qc [3];
      bit  busy_pre;
      exp_t e;
      nm_r = nm; we_r = w; wa_r = 10'(wa);
      vx_r = 6'(vx); vy_r = 6'(vy); cx_r = 6'(cx); cy_r = 6'(cy);
      busy_pre = mbusy;
      for (int d = 0; d < 3; d++) begin
         qv[d] = ref_tile(d, vx, vy, busy_pre);
         qc[d] = ref_tile(d, cx, cy, busy_pre);
      end
      if (nm) begin
         logic [15:0] l;
         if (mbusy) begin
            l = fill_start_lfsr;
            for (int k = 0; k < (891 - fill_left) + 1; k++) l = lfsr_next(l);
         end else begin
            l = lfsr_after;
         end
         gen_maps(l);
         fill_left = 891;
         mbusy     = 1'b1;
      end else if (mbusy) begin
         fill_left--;
         if (fill_left == 0) mbusy = 1'b0;
      end else if (w && wa <= 890) begin
         for (int d = 0; d < 3; d++) begin
            if (mmap[d][wa]) begin
               mmap[d][wa] = 1'b0;
               mcnt[d]--;
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         e.at_cyc = cyc + 1;
         e.d      = d;
         e.vga    = qv[d];
         e.col    = qc[d];
         e.busy   = mbusy;
         e.chk_bl = !mbusy;
         e.bl     = mcnt[d];
         e.ac     = !mbusy && (mcnt[d] == 0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      nm_r = 1'b0;
      we_r = 1'b0;
   endtask

   function automatic int rx();
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 32));
   endfunction

   function automatic int ry();
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(27, 63)) : int'($urandom_range(0, 26));
   endfunction

   // Runs fill cycles (with ignored random clears) until the d256 instance drops busy.
   task automatic run_fill(input string name);
      int n_fall;
      n_fall = -1;
      for (int n = 1; n <= 2000; n++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), rx(), ry(), rx(), ry());
         if (!busy_o[1]) begin
            n_fall = n;
            break;
         end
      end
      chk(name, n_fall, 891);
   endtask

   int scan_a [891];
   int scan_b [891];

   task automatic scan_map(output int res [891]);
      for (int i = 0; i < 891; i++) begin
         cycle(1'b0, 1'b0, 0, i % 33, i / 33, rx(), ry());
         res[i] = int'(vga_o[0]);
      end
   endtask

   int qx [5] = '{0, 1, 2, 33, 0};
   int qy [5] = '{0, 1, 0, 0, 27};
   int qe [5] = '{0, 2, 1, 2, 2};

   initial begin
      int wa, vx, vy, ndiff;
      reset_n = 1'b0;
      nm_r = 1'b0; we_r = 1'b0; wa_r = '0;
      vx_r = '0; vy_r = '0; cx_r = '0; cy_r = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_busy_d%0d", d), int'(busy_o[d]), 1);
         chk($sformatf("rst_left_d%0d", d), int'(bl_o[d]), 0);
         chk($sformatf("rst_allclr_d%0d", d), int'(ac_o[d]), 0);
         chk($sformatf("rst_vga_d%0d", d), int'(vga_o[d]), 0);
         chk($sformatf("rst_col_d%0d", d), int'(col_o[d]), 0);
      end

      @(negedge clk);
      reset_n   = 1'b1;
      mbusy     = 1'b1;
      fill_left = 891;
      gen_maps(16'hACE1);
      run_fill("fill_len_reset");

      chk("d256_left_full", int'(bl_o[1]), 680);
      chk("d0_left_empty", int'(bl_o[2]), 0);
      chk("d0_all_clear", int'(ac_o[2]), 1);
      chk("d256_not_clear", int'(ac_o[1]), 0);

      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 0, qx[i], qy[i], qx[i], qy[i]);
         chk($sformatf("d256_query_%0d_%0d", qx[i], qy[i]), int'(vga_o[1]), qe[i]);
      end

      cycle(1'b0, 1'b1, 2, 2, 0, 2, 0);
      chk("clr2_prewrite_read", int'(vga_o[1]), 1);
      chk("clr2_left", int'(bl_o[1]), 679);
      cycle(1'b0, 1'b1, 2, 2, 0, 2, 0);
      chk("clr2_postwrite_read", int'(vga_o[1]), 0);
      chk("clr2_repeat_left", int'(bl_o[1]), 679);
      cycle(1'b0, 1'b1, 34, 1, 1, 1, 1);
      chk("clr_pillar_left", int'(bl_o[1]), 679);
      cycle(1'b0, 1'b1, 900, 0, 0, 0, 0);
      chk("clr_oob_left", int'(bl_o[1]), 679);

      for (int i = 0; i < 600; i++) begin
         wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(891, 1023)) : int'($urandom_range(0, 890));
         vx = rx();
         vy = ry();
         if ($urandom_range(0, 3) == 0 && wa <= 890) begin
            vx = wa % 33;
            vy = wa / 33;
         end
         cycle(1'b0, 1'($urandom_range(0, 1)), wa, vx, vy, rx(), ry());
      end

      cycle(1'b1, 1'b1, 4, rx(), ry(), rx(), ry());
      for (int i = 0; i < 400; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 890)), rx(), ry(), rx(), ry());
      cycle(1'b1, 1'b0, 0, rx(), ry(), rx(), ry());
      run_fill("fill_len_restart");
      chk("d256_left_after_restart", int'(bl_o[1]), 680);

      scan_map(scan_a);
      cycle(1'b1, 1'b0, 0, rx(), ry(), rx(), ry());
      run_fill("fill_len_newmap");
      scan_map(scan_b);
      ndiff = 0;
      for (int i = 0; i < 891; i++) if (scan_a[i] != scan_b[i]) ndiff++;
      checks++;
      if (ndiff == 0) begin
         failures++;
         $display("FAIL maps_differ actual_diffs=%0d required=nonzero", ndiff);
      end

      @(negedge clk);
      #2;
      chk("sb_drain", sb.size(), 0);

      reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("midrst_busy_d%0d", d), int'(busy_o[d]), 1);
         chk($sformatf("midrst_left_d%0d", d), int'(bl_o[d]), 0);
         chk($sformatf("midrst_allclr_d%0d", d), int'(ac_o[d]), 0);
         chk($sformatf("midrst_vga_d%0d", d), int'(vga_o[d]), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
